mem_map_decoder: RTL and testbench

MEM_MAP_DECODER -- requirements
Module: mem_map_decoder

---
 rtl/board_pkg.sv | 21 ++
 rtl/mem_map_decoder_if.sv | 28 ++
 rtl/mem_region_decode.sv | 41 ++++
 rtl/mem_map_decoder.sv | 111 +++++++++++
 tb/tb_mem_map_decoder.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/board_pkg.sv
// Shared board-level types for the memory map decoder: config straps and access targets.
package board_pkg;

  typedef struct packed {
    logic [3:0] bank_mask;
    logic       rom_2mbit;
  } board_cfg_t;

  typedef enum logic [1:0] {
    TGT_ROM,
    TGT_RAM,
    TGT_GA25,
    TGT_PALRAM
  } mem_target_t;

  localparam logic [3:0] REGION_BANKED = 4'h8;
  localparam logic [3:0] REGION_RAM    = 4'hA;
  localparam logic [3:0] REGION_GA25   = 4'hD;
  localparam logic [3:0] REGION_PALRAM = 4'hE;

endpackage

// File: rtl/mem_map_decoder_if.sv
// CPU/IO/ROM bus bundle between the CPU side (master) and the map decoder (slave).
interface mem_map_decoder_if #(
  parameter int ROM_AW = 24
);
  logic [19:0]       cpu_addr;
  logic              cpu_mrq;
  logic              io_wr;
  logic [7:0]        io_addr;
  logic [7:0]        io_din;
  logic              rom_req;
  logic              rom_ack;
  logic [ROM_AW-1:0] rom_addr;
  logic              ram_sel;
  logic              ga25_sel;
  logic              palram_sel;
  logic              cpu_ready;
  logic              busy;

  modport master (
    output cpu_addr, cpu_mrq, io_wr, io_addr, io_din, rom_ack,
    input  rom_req, rom_addr, ram_sel, ga25_sel, palram_sel, cpu_ready, busy
  );

  modport slave (
    input  cpu_addr, cpu_mrq, io_wr, io_addr, io_din, rom_ack,
    output rom_req, rom_addr, ram_sel, ga25_sel, palram_sel, cpu_ready, busy
  );
endinterface

// File: rtl/mem_region_decode.sv
// Combinational address decode: CPU address + bank registers + board straps -> target and ROM address.
module mem_region_decode
  import board_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int ROM_AW    = 24,
  parameter int BANK_W    = 4
) (
  input  logic [19:0]                      addr_i,
  input  logic [NUM_BANKS-1:0][BANK_W-1:0] banks_i,
  input  board_cfg_t                       cfg_i,
  output mem_target_t                      tgt_o,
  output logic [ROM_AW-1:0]                rom_addr_o
);
  localparam int SEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic [3:0]       region;
  logic [3:0]       bank_val;
  logic [3:0]       bank_hi;
  logic [SEL_W-1:0] win;
  logic [19:0]      rom20;

  always_comb begin
    region   = addr_i[19:16];
    // Window index comes from the top address bits of the 64KB window.
    win      = (NUM_BANKS > 1) ? addr_i[15 -: SEL_W] : '0;
    bank_val = '0;
    if (int'(win) < NUM_BANKS) bank_val = 4'(banks_i[win]);
    bank_hi  = (bank_val & cfg_i.bank_mask) | (region & ~cfg_i.bank_mask);
    tgt_o    = TGT_ROM;
    rom20    = cfg_i.rom_2mbit ? {2'b00, addr_i[17:0]} : {1'b0, addr_i[18:0]};
    case (region)
      REGION_BANKED: rom20 = {bank_hi, addr_i[15:0]};
      REGION_RAM:    tgt_o = TGT_RAM;
      REGION_GA25:   tgt_o = TGT_GA25;
      REGION_PALRAM: tgt_o = TGT_PALRAM;
      default:       ;
    endcase
    rom_addr_o = ROM_AW'(rom20);
  end
endmodule

// File: rtl/mem_map_decoder.sv
// Memory map decoder: banked/linear ROM fetch with req/ack handshake, one-shot selects for RAM/GA25/palette.
module mem_map_decoder
  import board_pkg::*;
#(
  parameter int         NUM_BANKS = 2,
  parameter int         ROM_AW    = 24,
  parameter int         BANK_W    = 4,
  parameter logic [7:0] BANK_PORT = 8'h04
) (
  input  logic       clk,
  input  logic       reset,
  input  board_cfg_t board_cfg,
  mem_map_decoder_if.slave bus
);
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ROM_WAIT = 2'd1;
  localparam logic [1:0] S_DONE     = 2'd2;

  logic [1:0]                      state_q, state_d;
  logic [NUM_BANKS-1:0][BANK_W-1:0] bank_q, bank_d;
  logic                            rom_req_q, rom_req_d;
  logic [ROM_AW-1:0]               rom_addr_q, rom_addr_d;
  logic                            ram_sel_q, ram_sel_d;
  logic                            ga25_sel_q, ga25_sel_d;
  logic                            pal_sel_q, pal_sel_d;
  logic                            rdy_q, rdy_d;
  mem_target_t                     dec_tgt;
  logic [ROM_AW-1:0]               dec_addr;

  // Decode uses the registered banks, so a bank write in the access cycle lands after it.
  mem_region_decode #(
    .NUM_BANKS(NUM_BANKS),
    .ROM_AW   (ROM_AW),
    .BANK_W   (BANK_W)
  ) u_dec (
    .addr_i    (bus.cpu_addr),
    .banks_i   (bank_q),
    .cfg_i     (board_cfg),
    .tgt_o     (dec_tgt),
    .rom_addr_o(dec_addr)
  );

  always_comb begin
    bank_d = bank_q;
    for (int i = 0; i < NUM_BANKS; i++)
      if (bus.io_wr && bus.io_addr == 8'(int'(BANK_PORT) + i))
        bank_d[i] = bus.io_din[BANK_W-1:0];

    state_d    = state_q;
    rom_req_d  = rom_req_q;
    rom_addr_d = rom_addr_q;
    ram_sel_d  = 1'b0;
    ga25_sel_d = 1'b0;
    pal_sel_d  = 1'b0;
    rdy_d      = 1'b0;
    case (state_q)
      S_IDLE: if (bus.cpu_mrq) begin
        case (dec_tgt)
          TGT_ROM: begin
            rom_req_d  = 1'b1;
            rom_addr_d = dec_addr;
            state_d    = S_ROM_WAIT;
          end
          TGT_RAM:    begin ram_sel_d  = 1'b1; state_d = S_DONE; end
          TGT_GA25:   begin ga25_sel_d = 1'b1; state_d = S_DONE; end
          TGT_PALRAM: begin pal_sel_d  = 1'b1; state_d = S_DONE; end
          default:    ;
        endcase
      end
      S_ROM_WAIT: if (bus.rom_ack) begin
        rom_req_d = 1'b0;
        state_d   = S_DONE;
      end
      S_DONE: begin
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      bank_q     <= '0;
      rom_req_q  <= 1'b0;
      rom_addr_q <= '0;
      ram_sel_q  <= 1'b0;
      ga25_sel_q <= 1'b0;
      pal_sel_q  <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      rom_req_q  <= rom_req_d;
      rom_addr_q <= rom_addr_d;
      ram_sel_q  <= ram_sel_d;
      ga25_sel_q <= ga25_sel_d;
      pal_sel_q  <= pal_sel_d;
      rdy_q      <= rdy_d;
    end
  end

  assign bus.rom_req    = rom_req_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.ram_sel    = ram_sel_q;
  assign bus.ga25_sel   = ga25_sel_q;
  assign bus.palram_sel = pal_sel_q;
  assign bus.cpu_ready  = rdy_q;
  assign bus.busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_map_decoder.sv
// Bench for mem_map_decoder: directed vector table, hand-written corner sequences, random vs. reference model.
module tb_mem_map_decoder;
  import board_pkg::*;

  localparam int T_ROM = 0, T_RAM = 1, T_GA = 2, T_PAL = 3;

  logic       clk = 1'b0;
  logic       reset;
  board_cfg_t cfg;
  int         total = 0;
  int         bad = 0;
  int         mbank[2];

  mem_map_decoder_if #(.ROM_AW(24)) bus();

  mem_map_decoder #(
    .NUM_BANKS(2),
    .ROM_AW   (24),
    .BANK_W   (4),
    .BANK_PORT(8'h04)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .board_cfg(cfg),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  b0;
    logic [3:0]  b1;
    logic [3:0]  mask;
    bit          r2;
    logic [19:0] addr;
    int          tgt;
    logic [23:0] eaddr;
  } vec_t;

  vec_t vt[12];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: map rules straight from the address map, using plain arithmetic.
  function automatic void model(input logic [19:0] a, output int tgt, output logic [23:0] ra);
    int region, w, hi, m;
    region = int'(a) / 65536;
    m      = int'(cfg.bank_mask);
    tgt    = T_ROM;
    ra     = cfg.rom_2mbit ? 24'(int'(a) % 262144) : 24'(int'(a) % 524288);
    if (region == 8) begin
      w  = (int'(a) / 32768) % 2;
      hi = (mbank[w] & m) | (region & (15 - m));
      ra = 24'(hi * 65536 + int'(a) % 65536);
    end
    else if (region == 10) tgt = T_RAM;
    else if (region == 13) tgt = T_GA;
    else if (region == 14) tgt = T_PAL;
  endfunction

  task automatic write_bank(input logic [7:0] port, input logic [7:0] data);
    bus.io_wr   = 1'b1;
    bus.io_addr = port;
    bus.io_din  = data;
    tick;
    bus.io_wr = 1'b0;
    if (port == 8'h04 || port == 8'h05) mbank[int'(port) - 4] = int'(data) % 16;
  endtask

  task automatic do_access(input logic [19:0] a, input int etgt, input logic [23:0] eaddr,
                           input int ackdly, input bit wr, input logic [7:0] wport,
                           input logic [7:0] wdata, input string tag);
    logic [2:0] esel;
    bus.cpu_addr = a;
    bus.cpu_mrq  = 1'b1;
    if (wr) begin
      bus.io_wr   = 1'b1;
      bus.io_addr = wport;
      bus.io_din  = wdata;
    end
    tick;
    bus.cpu_mrq = 1'b0;
    bus.io_wr   = 1'b0;
    if (etgt == T_ROM) begin
      chk({tag, ".rom_req"}, bus.rom_req, 1);
      chk({tag, ".rom_addr"}, bus.rom_addr, eaddr);
      chk({tag, ".busy"}, bus.busy, 1);
      chk({tag, ".sels"}, {bus.ram_sel, bus.ga25_sel, bus.palram_sel}, 0);
      repeat (ackdly) begin
        tick;
        chk({tag, ".rom_req_hold"}, {bus.rom_req, bus.rom_addr}, {1'b1, eaddr});
      end
      bus.rom_ack = 1'b1;
      tick;
      bus.rom_ack = 1'b0;
      chk({tag, ".rom_req_drop"}, bus.rom_req, 0);
      chk({tag, ".ready_early"}, bus.cpu_ready, 0);
      tick;
      chk({tag, ".ready"}, bus.cpu_ready, 1);
      chk({tag, ".busy_end"}, bus.busy, 0);
    end else begin
      esel = (etgt == T_RAM) ? 3'b100 : (etgt == T_GA) ? 3'b010 : 3'b001;
      chk({tag, ".sel"}, {bus.ram_sel, bus.ga25_sel, bus.palram_sel}, esel);
      chk({tag, ".rom_req"}, bus.rom_req, 0);
      chk({tag, ".ready_early"}, bus.cpu_ready, 0);
      bus.rom_ack = 1'b1;
      tick;
      bus.rom_ack = 1'b0;
      chk({tag, ".sel_drop"}, {bus.ram_sel, bus.ga25_sel, bus.palram_sel}, 0);
      chk({tag, ".ready"}, bus.cpu_ready, 1);
      chk({tag, ".rom_req_idle"}, bus.rom_req, 0);
    end
    tick;
    chk({tag, ".ready_drop"}, bus.cpu_ready, 0);
  endtask

  initial begin
    int          etgt;
    logic [23:0] eaddr;
    logic [19:0] a;
    logic [3:0]  region;
    logic [7:0]  wport, wdata;
    bit          wr;

    vt[0]  = '{4'h0, 4'h0, 4'hF, 1'b0, 20'h81234, T_ROM, 24'h001234};
    vt[1]  = '{4'h0, 4'h3, 4'h3, 1'b0, 20'h89ABC, T_ROM, 24'h0B9ABC};
    vt[2]  = '{4'h0, 4'h0, 4'hF, 1'b1, 20'h7FFFE, T_ROM, 24'h03FFFE};
    vt[3]  = '{4'h0, 4'h0, 4'hF, 1'b0, 20'h7FFFE, T_ROM, 24'h07FFFE};
    vt[4]  = '{4'h0, 4'h0, 4'hF, 1'b0, 20'hE0010, T_PAL, 24'h000000};
    vt[5]  = '{4'h0, 4'h0, 4'hF, 1'b0, 20'hA5555, T_RAM, 24'h000000};
    vt[6]  = '{4'h0, 4'h0, 4'hF, 1'b0, 20'hDFFFF, T_GA,  24'h000000};
    vt[7]  = '{4'hA, 4'h0, 4'hF, 1'b0, 20'h87FFF, T_ROM, 24'h0A7FFF};
    vt[8]  = '{4'h5, 4'hC, 4'h0, 1'b0, 20'h88000, T_ROM, 24'h088000};
    vt[9]  = '{4'h0, 4'h0, 4'hF, 1'b1, 20'hF0001, T_ROM, 24'h030001};
    vt[10] = '{4'h0, 4'hF, 4'hC, 1'b0, 20'h8C000, T_ROM, 24'h0CC000};
    vt[11] = '{4'h0, 4'h0, 4'hF, 1'b0, 20'h90000, T_ROM, 24'h010000};

    reset        = 1'b1;
    cfg          = '{bank_mask: 4'hF, rom_2mbit: 1'b0};
    bus.cpu_addr = '0;
    bus.cpu_mrq  = 1'b0;
    bus.io_wr    = 1'b0;
    bus.io_addr  = '0;
    bus.io_din   = '0;
    bus.rom_ack  = 1'b0;
    mbank[0] = 0;
    mbank[1] = 0;

    tick;
    tick;
    chk("reset.outs", {bus.rom_req, bus.ram_sel, bus.ga25_sel, bus.palram_sel,
                       bus.cpu_ready, bus.busy}, 0);
    chk("reset.rom_addr", bus.rom_addr, 0);
    reset = 1'b0;
    tick;

    for (int i = 0; i < 12; i++) begin
      write_bank(8'h04, {4'h0, vt[i].b0});
      write_bank(8'h05, {4'h0, vt[i].b1});
      cfg.bank_mask = vt[i].mask;
      cfg.rom_2mbit = vt[i].r2;
      do_access(vt[i].addr, vt[i].tgt, vt[i].eaddr, (i + 3) % 5, 1'b0, 8'h00, 8'h00,
                $sformatf("vec%0d", i));
    end

    // Bank write coincident with the access: the access sees the old bank value.
    write_bank(8'h04, 8'h00);
    cfg = '{bank_mask: 4'hF, rom_2mbit: 1'b0};
    do_access(20'h80000, T_ROM, 24'h000000, 1, 1'b1, 8'h04, 8'h05, "coinc.old");
    mbank[0] = 5;
    do_access(20'h80000, T_ROM, 24'h050000, 0, 1'b0, 8'h00, 8'h00, "coinc.new");

    // Reset during ROM_WAIT, with an ignored mrq while busy and a bank write under reset.
    write_bank(8'h04, 8'h07);
    bus.cpu_addr = 20'h81234;
    bus.cpu_mrq  = 1'b1;
    tick;
    chk("rst.rom_req", bus.rom_req, 1);
    bus.cpu_addr = 20'hA0000;
    tick;
    bus.cpu_mrq = 1'b0;
    chk("rst.busy_ignore", {bus.ram_sel, bus.rom_req, bus.busy}, 3'b011);
    reset       = 1'b1;
    bus.io_wr   = 1'b1;
    bus.io_addr = 8'h04;
    bus.io_din  = 8'h09;
    tick;
    reset     = 1'b0;
    bus.io_wr = 1'b0;
    mbank[0]  = 0;
    mbank[1]  = 0;
    chk("rst.drop", {bus.rom_req, bus.busy, bus.cpu_ready}, 0);
    chk("rst.rom_addr", bus.rom_addr, 0);
    bus.rom_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk($sformatf("rst.quiet%0d", k), {bus.rom_req, bus.busy, bus.cpu_ready}, 0);
    end
    bus.rom_ack = 1'b0;
    do_access(20'h81234, T_ROM, 24'h001234, 0, 1'b0, 8'h00, 8'h00, "rst.banks");

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0)
        write_bank(8'($urandom_range(3, 6)), 8'($urandom));
      cfg.bank_mask = 4'($urandom);
      cfg.rom_2mbit = 1'($urandom);
      case ($urandom_range(0, 5))
        0, 1:    region = 4'h8;
        2:       region = 4'hA;
        3:       region = 4'hD;
        4:       region = 4'hE;
        default: region = 4'($urandom);
      endcase
      a     = {region, 16'($urandom)};
      wr    = ($urandom_range(0, 2) == 0);
      wport = 8'($urandom_range(3, 6));
      wdata = 8'($urandom);
      model(a, etgt, eaddr);
      do_access(a, etgt, eaddr, $urandom_range(0, 4), wr, wport, wdata, $sformatf("rnd%0d", n));
      if (wr && (wport == 8'h04 || wport == 8'h05)) mbank[int'(wport) - 4] = int'(wdata) % 16;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
